network_if_rr_arbiter: RTL
==========================

NETWORK_IF_RR_ARBITER -- requirements
Module: network_if_rr_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_INPUTS, default 4, meaning the number of upstream network_if slave ports (legal range 2..16).
REQ-002 The module SHALL have parameter SRC_WIDTH, default $clog2(NUM_INPUTS), meaning the width of the source-index output.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The module SHALL have port in, network_if.slave array [NUM_INPUTS], the upstream val/id/valid/ready streams.
REQ-006 The module SHALL have port out, network_if.master, the merged stream that feeds network_if_copier.
REQ-007 The module SHALL have port out_src, output, SRC_WIDTH, the index of the input that produced the word currently on out.

Function
REQ-008 The module SHALL register out.val, out.id, out.valid and out_src (one output stage, latency 1 cycle from accepted input to out.valid).
REQ-009 The module SHALL define load = !out.valid || out.ready; the output register captures only when load is 1.
REQ-010 The module SHALL drive in[k].ready = load && grant_valid && (grant == k); all other inputs see ready 0.
REQ-011 The module SHALL compute grant combinationally as the first k with in[k].valid, searched from rr_ptr upward, wrapping modulo NUM_INPUTS; grant_valid = OR of all in[k].valid.
REQ-012 A transfer on input k SHALL occur when in[k].valid && in[k].ready; the register then loads val and id from input k (width-cast to out.IN_WIDTH and out.ID_WIDTH) and out_src = k, and sets out.valid = 1.
REQ-013 On a transfer from input k, rr_ptr SHALL update to (k+1) mod NUM_INPUTS; with no transfer, rr_ptr holds.
REQ-014 When load = 1 and no input is valid, out.valid SHALL go to 0 on the next edge; val, id and out_src hold.
REQ-015 When out.valid && !out.ready, out.val, out.id and out_src SHALL stay stable and every in[k].ready SHALL be 0.
REQ-016 Simultaneous drain and fill (out.ready = 1 with a granted valid input) SHALL sustain one word per cycle with no bubble.
REQ-017 in[k].ready SHALL NOT depend on in[k].valid of the same port, except through the grant search, so that no input starves: any continuously valid input is accepted within NUM_INPUTS accepted transfers.
REQ-018 The rr_ptr wrap from NUM_INPUTS-1 SHALL go to 0, including non-power-of-two NUM_INPUTS.

Reset
REQ-019 On rst_n low, asynchronously, out.valid SHALL be 0, out.val 0, out.id 0, out_src 0 and rr_ptr 0.
REQ-020 A reset asserted mid-stall SHALL discard the held word; the held word SHALL NOT be re-presented after reset release.
REQ-021 The first cycle after release SHALL behave as load = 1 with priority starting at input 0.

Structure
REQ-022 The rr_ptr/grant search SHALL be a sub-module rr_grant (inputs req vector and ptr, outputs grant index and grant_valid), reusable by other arbiters.
REQ-023 Width-check constants and the helper function for modulo-increment of the pointer SHALL live in the shared network package; no new typedefs are required.

Verification
REQ-024 NUM_INPUTS = 4; inputs 0..3 all continuously valid, out.ready = 1 -> out_src sequence 0,1,2,3,0,..., one word per cycle after 1-cycle latency.
REQ-025 Only input 2 valid with val = 0x2A, id = 5 -> out.val = 0x2A, out.id = 5, out_src = 2 one cycle later; rr_ptr = 3.
REQ-026 out.ready held 0 for 5 cycles with a word loaded -> out.val/id/src stable and all in[k].ready = 0 for those cycles; on release the word is taken and the next word follows with no bubble.
REQ-027 NUM_INPUTS = 3, grants 0,1,2 then inputs 0 and 2 valid -> next grant is 0 (pointer wrapped 2 -> 0), then 2.
REQ-028 rst_n pulsed low while out.valid = 1 and out.ready = 0 -> out.valid 0 immediately; after release the first grant goes to the lowest valid index from 0.
REQ-029 Random valid/ready on all ports for 10k cycles against a scoreboard -> per-source order preserved, no loss or duplication, no input waits more than NUM_INPUTS grants.

Source files
------------

// File: rtl/network_if_rr_arbiter_pkg.sv
// Shared definitions for the network_if round-robin arbiter.
//   MIN_INPUTS / MAX_INPUTS : legal range of upstream ports.
//   ptr_inc()               : modulo increment of a round-robin pointer.
//                             Works for any port count, not only powers of two.
package network_if_rr_arbiter_pkg;

   localparam int MIN_INPUTS = 2;
   localparam int MAX_INPUTS = 16;

   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/network_if.sv
// Valid/ready word stream carrying a value and an id.
//   master : drives val, id, valid; receives ready.
//   slave  : receives val, id, valid; drives ready.
interface network_if #(
   parameter int IN_WIDTH = 8,
   parameter int ID_WIDTH = 4
);
   logic [IN_WIDTH-1:0] val;
   logic [ID_WIDTH-1:0] id;
   logic                valid;
   logic                ready;

   modport master (output val, output id, output valid, input ready);
   modport slave  (input val, input id, input valid, output ready);
endinterface

// File: rtl/network_if_rr_arbiter_rr_grant.sv
// Combinational round-robin grant search, reusable by other arbiters.
//   req         : request vector, one bit per requester.
//   ptr         : index where the search starts (highest priority).
//   grant       : first requesting index found from ptr upward, wrapping at N.
//   grant_valid : at least one request is present.
module rr_grant #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant,
   output logic         grant_valid
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   always_comb begin
      int   idx;
      logic found;
      grant       = ptr;
      grant_valid = |req;
      found       = 1'b0;
      idx         = 0;
      for (int i = 0; i < N; i++) begin
         // explicit modulo keeps the wrap correct for non-power-of-two N
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx[IW-1:0]]) begin
            found = 1'b1;
            grant = W'(idx);
         end
      end
   end

endmodule

// File: rtl/network_if_rr_arbiter.sv
// Round-robin merge of NUM_INPUTS network_if streams into one registered stream.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset.
//   in[]       : upstream slave ports; only the granted port sees ready.
//   out        : merged master stream, one register stage (latency 1).
//   out_src    : index of the input that produced the word on out.
module network_if_rr_arbiter
   import network_if_rr_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS = 4,
   parameter int SRC_WIDTH  = $clog2(NUM_INPUTS),
   parameter int IN_WIDTH   = 8,
   parameter int ID_WIDTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   network_if.slave             in [NUM_INPUTS],
   network_if.master            out,
   output logic [SRC_WIDTH-1:0] out_src
);

   if (NUM_INPUTS < MIN_INPUTS || NUM_INPUTS > MAX_INPUTS) begin : g_bad_inputs
      $error("network_if_rr_arbiter: NUM_INPUTS out of range");
   end
   if (SRC_WIDTH < $clog2(NUM_INPUTS)) begin : g_bad_src_width
      $error("network_if_rr_arbiter: SRC_WIDTH too narrow");
   end

   logic [NUM_INPUTS-1:0] req;
   logic [IN_WIDTH-1:0]   in_val [NUM_INPUTS];
   logic [ID_WIDTH-1:0]   in_id  [NUM_INPUTS];
   logic [SRC_WIDTH-1:0]  grant;
   logic                  grant_valid;
   logic [SRC_WIDTH-1:0]  rr_ptr;
   logic                  load;

   logic                  valid_q;
   logic [IN_WIDTH-1:0]   val_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [SRC_WIDTH-1:0]  src_q;

   // The output register may capture whenever it is empty or being drained.
   assign load = !valid_q || out.ready;

   for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_in
      assign req[k]    = in[k].valid;
      assign in_val[k] = IN_WIDTH'(in[k].val);
      assign in_id[k]  = ID_WIDTH'(in[k].id);
      // ready depends on this port's valid only through the grant search
      assign in[k].ready = load && grant_valid && (grant == SRC_WIDTH'(k));
   end

   rr_grant #(
      .N (NUM_INPUTS),
      .W (SRC_WIDTH)
   ) u_rr_grant (
      .req         (req),
      .ptr         (rr_ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Output stage: reset discards any held word so it is never re-presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         val_q   <= '0;
         id_q    <= '0;
         src_q   <= '0;
         rr_ptr  <= '0;
      end else if (load) begin
         valid_q <= grant_valid;
         if (grant_valid) begin
            val_q  <= in_val[grant];
            id_q   <= in_id[grant];
            src_q  <= grant;
            rr_ptr <= SRC_WIDTH'(ptr_inc(32'(grant), NUM_INPUTS));
         end
      end
   end

   assign out.valid = valid_q;
   assign out.val   = val_q;
   assign out.id    = id_q;
   assign out_src   = src_q;

endmodule
